// File: rtl/arch_regfile_sb_pkg.sv
// Shared types for the architectural register file and its scoreboard lookup.
package arch_regfile_sb_pkg;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned TagW    = 4;
  localparam int unsigned Xlen    = 32;

  typedef logic [4:0]      arch_reg_t;
  typedef logic [TagW-1:0] rob_tag_t;
  typedef logic [Xlen-1:0] word_t;

  typedef struct packed {
    word_t    val;
    logic     ready;
    rob_tag_t rob;
  } regfile_read_t;

endpackage

// File: rtl/regfile_src_lookup.sv
// Resolves one source operand against same-group issues, same-cycle commits and the scoreboard.
module regfile_src_lookup
  import arch_regfile_sb_pkg::*;
#(
  parameter int unsigned Ways = 2,
  parameter int unsigned Slot = 0
) (
  input  arch_reg_t                rs_i,
  input  logic                     busy_i,
  input  rob_tag_t                 tag_i,
  input  word_t                    stored_i,
  input  logic     [Ways-1:0]      issue_valid_i,
  input  arch_reg_t [Ways-1:0]     issue_rd_i,
  input  rob_tag_t [Ways-1:0]      issue_rob_i,
  input  logic     [Ways-1:0]      commit_we_i,
  input  arch_reg_t [Ways-1:0]     commit_rd_i,
  input  word_t    [Ways-1:0]      commit_val_i,
  input  rob_tag_t [Ways-1:0]      commit_rob_i,
  output regfile_read_t            res_o
);

  logic     hit_issue, hit_commit;
  rob_tag_t issue_tag;
  word_t    commit_val;

  always_comb begin
    hit_issue  = 1'b0;
    hit_commit = 1'b0;
    issue_tag  = '0;
    commit_val = '0;
    // Only older slots count; ascending loop leaves the highest match.
    for (int unsigned j = 0; j < Slot; j++) begin
      if (issue_valid_i[j] && issue_rd_i[j] == rs_i) begin
        hit_issue = 1'b1;
        issue_tag = issue_rob_i[j];
      end
    end
    for (int unsigned k = 0; k < Ways; k++) begin
      if (commit_we_i[k] && commit_rd_i[k] == rs_i && commit_rob_i[k] == tag_i) begin
        hit_commit = 1'b1;
        commit_val = commit_val_i[k];
      end
    end

    res_o = '{val: stored_i, ready: 1'b1, rob: '0};
    if (rs_i == '0) begin
      res_o = '{val: '0, ready: 1'b1, rob: '0};
    end else if (hit_issue) begin
      res_o = '{val: '0, ready: 1'b0, rob: issue_tag};
    end else if (busy_i && hit_commit) begin
      res_o = '{val: commit_val, ready: 1'b1, rob: '0};
    end else if (busy_i) begin
      res_o = '{val: '0, ready: 1'b0, rob: tag_i};
    end
  end

endmodule

// File: rtl/arch_regfile_sb.sv
// 32-entry architectural register file with busy/producer-tag scoreboard, WAYS-wide issue/commit.
module arch_regfile_sb
  import arch_regfile_sb_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned TAG_W = TagW,
  parameter int unsigned XLEN  = Xlen
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [WAYS-1:0]             commit_we,
  input  logic [WAYS-1:0][4:0]        commit_rd,
  input  logic [WAYS-1:0][XLEN-1:0]   commit_val,
  input  logic [WAYS-1:0][TAG_W-1:0]  commit_rob,
  input  logic [WAYS-1:0]             issue_valid,
  input  logic [WAYS-1:0][4:0]        issue_rd,
  input  logic [WAYS-1:0][TAG_W-1:0]  issue_rob,
  input  logic [WAYS-1:0][4:0]        issue_rs1,
  input  logic [WAYS-1:0][4:0]        issue_rs2,
  output logic [WAYS-1:0][XLEN-1:0]   rs1_val,
  output logic [WAYS-1:0][XLEN-1:0]   rs2_val,
  output logic [WAYS-1:0]             rs1_ready,
  output logic [WAYS-1:0]             rs2_ready,
  output logic [WAYS-1:0][TAG_W-1:0]  rs1_rob,
  output logic [WAYS-1:0][TAG_W-1:0]  rs2_rob
);

  word_t    val_q  [NumRegs];
  rob_tag_t tag_q  [NumRegs];
  logic     busy_q [NumRegs];

  // Later slots overwrite earlier ones; issues follow commits so issue wins on the same rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NumRegs; r++) begin
        val_q[r]  <= '0;
        tag_q[r]  <= '0;
        busy_q[r] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        if (commit_we[i] && commit_rd[i] != '0) begin
          val_q[commit_rd[i]] <= commit_val[i];
          if (busy_q[commit_rd[i]] && tag_q[commit_rd[i]] == commit_rob[i]) begin
            busy_q[commit_rd[i]] <= 1'b0;
          end
        end
      end
      for (int i = 0; i < WAYS; i++) begin
        if (!flush && issue_valid[i] && issue_rd[i] != '0) begin
          busy_q[issue_rd[i]] <= 1'b1;
          tag_q[issue_rd[i]]  <= issue_rob[i];
        end
      end
      if (flush) begin
        for (int r = 0; r < NumRegs; r++) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_slot
    regfile_read_t r1, r2;

    regfile_src_lookup #(.Ways(WAYS), .Slot(i)) u_rs1 (
      .rs_i          (issue_rs1[i]),
      .busy_i        (busy_q[issue_rs1[i]]),
      .tag_i         (tag_q[issue_rs1[i]]),
      .stored_i      (val_q[issue_rs1[i]]),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .issue_rob_i   (issue_rob),
      .commit_we_i   (commit_we),
      .commit_rd_i   (commit_rd),
      .commit_val_i  (commit_val),
      .commit_rob_i  (commit_rob),
      .res_o         (r1)
    );

    regfile_src_lookup #(.Ways(WAYS), .Slot(i)) u_rs2 (
      .rs_i          (issue_rs2[i]),
      .busy_i        (busy_q[issue_rs2[i]]),
      .tag_i         (tag_q[issue_rs2[i]]),
      .stored_i      (val_q[issue_rs2[i]]),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .issue_rob_i   (issue_rob),
      .commit_we_i   (commit_we),
      .commit_rd_i   (commit_rd),
      .commit_val_i  (commit_val),
      .commit_rob_i  (commit_rob),
      .res_o         (r2)
    );

    assign rs1_val[i]   = r1.val;
    assign rs1_ready[i] = r1.ready;
    assign rs1_rob[i]   = r1.rob;
    assign rs2_val[i]   = r2.val;
    assign rs2_ready[i] = r2.ready;
    assign rs2_rob[i]   = r2.rob;
  end

endmodule

// File: tb/tb_arch_regfile_sb.sv
// Directed checks of the register file scoreboard with hand-computed expectations.
module tb_arch_regfile_sb;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic [1:0]       commit_we, issue_valid;
  logic [1:0][4:0]  commit_rd, issue_rd, issue_rs1, issue_rs2;
  logic [1:0][31:0] commit_val, rs1_val, rs2_val;
  logic [1:0][3:0]  commit_rob, issue_rob, rs1_rob, rs2_rob;
  logic [1:0]       rs1_ready, rs2_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  arch_regfile_sb #(.WAYS(2), .TAG_W(4), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .commit_we   (commit_we),
    .commit_rd   (commit_rd),
    .commit_val  (commit_val),
    .commit_rob  (commit_rob),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rob   (issue_rob),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .rs1_ready   (rs1_ready),
    .rs2_ready   (rs2_ready),
    .rs1_rob     (rs1_rob),
    .rs2_rob     (rs2_rob)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0;
    commit_we = '0; commit_rd = '0; commit_val = '0; commit_rob = '0;
    issue_valid = '0; issue_rd = '0; issue_rob = '0; issue_rs1 = '0; issue_rs2 = '0;
  endtask

  // Drive after the edge, let combinational reads settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input int s, input int rd, input int tag);
    issue_valid[s] = 1'b1; issue_rd[s] = 5'(rd); issue_rob[s] = 4'(tag);
  endtask

  task automatic commit(input int s, input int rd, input int tag, input logic [31:0] v);
    commit_we[s] = 1'b1; commit_rd[s] = 5'(rd); commit_rob[s] = 4'(tag); commit_val[s] = v;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();

    // Reset state
    issue_rs1[0] = 5; issue_rs2[0] = 5; issue_rs1[1] = 5; issue_rs2[1] = 5; settle();
    check("rst_s0_rdy", rs1_ready[0], 1); check("rst_s0_val", rs1_val[0], 0);
    check("rst_s1_rdy", rs2_ready[1], 1); check("rst_s1_val", rs1_val[1], 0);
    check("rst_s0_rob", rs1_rob[0], 0);

    // Issue x3 tag 7, then bypass a matching commit
    issue(0, 3, 7); tick();
    issue_rs1[0] = 3; settle();
    check("x3_busy_rdy", rs1_ready[0], 0); check("x3_busy_rob", rs1_rob[0], 7);
    check("x3_busy_val", rs1_val[0], 0);
    commit(0, 3, 7, 32'hAA); issue_rs1[0] = 3; settle();
    check("x3_byp_rdy", rs1_ready[0], 1); check("x3_byp_val", rs1_val[0], 32'hAA);
    tick();
    issue_rs1[0] = 3; settle();
    check("x3_done_rdy", rs1_ready[0], 1); check("x3_done_val", rs1_val[0], 32'hAA);

    // Stale-tag commit leaves the newer producer busy
    issue(0, 4, 2); tick();
    issue(0, 4, 5); tick();
    commit(0, 4, 2, 32'h11); tick();
    issue_rs1[0] = 4; settle();
    check("x4_rdy", rs1_ready[0], 0); check("x4_rob", rs1_rob[0], 5);
    flush = 1'b1; tick();
    issue_rs1[0] = 4; settle();
    check("x4_val", rs1_val[0], 32'h11); check("x4_flush_rdy", rs1_ready[0], 1);

    // Intra-group dependency; slot0 reading its own rd sees prior state
    issue(0, 6, 1); issue_rs1[0] = 6; issue_rs1[1] = 6; issue_rs2[1] = 6; settle();
    check("grp_s1_rdy", rs1_ready[1], 0); check("grp_s1_rob", rs1_rob[1], 1);
    check("grp_s1_rs2_rob", rs2_rob[1], 1); check("grp_s0_rdy", rs1_ready[0], 1);
    check("grp_s0_val", rs1_val[0], 0);
    tick();

    // Issue beats matching commit on the same rd
    issue(0, 6, 9); commit(1, 6, 1, 32'h33); issue_rs1[0] = 6; settle();
    check("x6_byp_val", rs1_val[0], 32'h33); check("x6_byp_rdy", rs1_ready[0], 1);
    tick();
    issue_rs1[0] = 6; settle();
    check("x6_reissue_rdy", rs1_ready[0], 0); check("x6_reissue_rob", rs1_rob[0], 9);
    commit(0, 6, 2, 32'h44); issue_rs1[0] = 6; settle();
    check("x6_mism_rdy", rs1_ready[0], 0); check("x6_mism_rob", rs1_rob[0], 9);
    tick();
    issue_rs1[0] = 6; settle();
    check("x6_still_busy", rs1_ready[0], 0);

    // Flush with concurrent commit and issue
    issue(0, 8, 3); issue(1, 9, 4); tick();
    flush = 1'b1; commit(0, 8, 3, 32'h22); issue(0, 10, 6); tick();
    issue_rs1[0] = 8; issue_rs2[0] = 9; issue_rs1[1] = 10; issue_rs2[1] = 6; settle();
    check("fl_x8_rdy", rs1_ready[0], 1); check("fl_x8_val", rs1_val[0], 32'h22);
    check("fl_x9_rdy", rs2_ready[0], 1); check("fl_x10_rdy", rs1_ready[1], 1);
    check("fl_x10_rob", rs1_rob[1], 0); check("fl_x6_val", rs2_val[1], 32'h44);

    // Highest slot wins for commit and for issue
    commit(0, 11, 0, 32'h55); commit(1, 11, 0, 32'h66); issue(0, 12, 1); issue(1, 12, 2);
    tick();
    issue_rs1[0] = 11; issue_rs2[0] = 12; settle();
    check("prio_commit", rs1_val[0], 32'h66); check("prio_issue", rs2_rob[0], 2);
    commit(0, 12, 2, 32'hA1); commit(1, 12, 2, 32'hB2); issue_rs1[1] = 12; settle();
    check("prio_byp", rs1_val[1], 32'hB2);
    tick();

    // x0 is hardwired
    commit(0, 0, 0, 32'hFF); issue(0, 0, 1); issue_rs1[1] = 0; settle();
    check("x0_grp_rdy", rs1_ready[1], 1); check("x0_grp_rob", rs1_rob[1], 0);
    tick();
    issue_rs1[0] = 0; settle();
    check("x0_rdy", rs1_ready[0], 1); check("x0_val", rs1_val[0], 0);
    check("x0_rob", rs1_rob[0], 0);

    // Reset overrides issue and commit
    issue(0, 13, 3); tick();
    rst = 1'b1; commit(0, 14, 0, 32'h77); issue(1, 15, 2); tick();
    issue_rs1[0] = 13; issue_rs2[0] = 14; issue_rs1[1] = 15; issue_rs2[1] = 11; settle();
    check("rst2_x13_rdy", rs1_ready[0], 1); check("rst2_x14_val", rs2_val[0], 0);
    check("rst2_x15_rdy", rs1_ready[1], 1); check("rst2_x11_val", rs2_val[1], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
